// File: rtl/rr_mux_reg_if.sv
// Channel-side and consumer-side handshake bundle for rr_mux_reg.
// slave is the mux's view, master is the producer/consumer side.
interface rr_mux_reg_if #(
  parameter int N = 8,
  parameter int W = 8
) ();
  localparam int SW = $clog2(N);

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    input  mode,
    input  sel,
    output out_data,
    output out_ch,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    output mode,
    output sel,
    input  out_data,
    input  out_ch,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/rr_mux_reg.sv
// Registered N:1 mux, round-robin or fixed select, valid/ready on all ports.
// RR_MUX_XFER_CNT_EN adds a saturating 16-bit output handshake counter.
module rr_mux_reg #(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
`ifdef RR_MUX_XFER_CNT_EN
  rr_mux_reg_if.slave  bus,
  output logic [15:0]  xfer_cnt
`else
  rr_mux_reg_if.slave  bus
`endif
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] idx;
  logic [SW-1:0] rr_idx;
  logic          rr_hit;
  logic          fx_in;
  logic          fx_hit;
  logic [SW-1:0] grant;
  logic          grant_valid;
  logic [N-1:0]  gnt_oh;
  logic [W-1:0]  mux_data;
  logic          free;
  logic          take;

  assign free = ~bus.out_valid | bus.out_ready;

  // Walk ptr+N down to ptr+1 so the nearest hit is written last.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    idx    = '0;
    for (int k = N; k >= 1; k--) begin
      idx = SW'((int'(ptr) + k) % N);
      if (bus.in_valid[idx]) begin
        rr_hit = 1'b1;
        rr_idx = idx;
      end
    end
  end

  assign fx_in  = {1'b0, bus.sel} < (SW+1)'(N);
  assign fx_hit = fx_in ? bus.in_valid[bus.sel] : 1'b0;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    unique case (1'b1)
      ~bus.mode: begin
        grant       = rr_idx;
        grant_valid = rr_hit;
      end
      bus.mode: begin
        grant       = bus.sel;
        grant_valid = fx_hit;
      end
    endcase
  end

  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < N; i++) begin
      gnt_oh[i] = grant_valid && (grant == SW'(i));
    end
  end

  // AND-OR mux keyed by the one-hot grant, never indexes out of range.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++) begin
      mux_data = mux_data
               | (bus.in_data[i*W +: W] & {W{gnt_oh[i]}});
    end
  end

  assign bus.in_ready = {N{free & ~rst}} & gnt_oh;
  assign take         = free & grant_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
    end else if (free) begin
      bus.out_valid <= grant_valid;
      if (grant_valid) begin
        bus.out_data <= mux_data;
        bus.out_ch   <= grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= SW'(N - 1);
    end else if (take && !bus.mode) begin
      ptr <= grant;
    end
  end

`ifdef RR_MUX_XFER_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready
                 && xfer_cnt != 16'hFFFF) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg, N=8, W=8.
// Outputs are sampled 1ns after the rising edge.
module tb_rr_mux_reg;
  localparam int N = 8;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
`ifdef RR_MUX_XFER_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  rr_mux_reg_if #(.N(N), .W(W)) bus ();

  rr_mux_reg #(.N(N), .W(W)) dut (
    .clk(clk),
    .rst(rst),
`ifdef RR_MUX_XFER_CNT_EN
    .bus(bus.slave),
    .xfer_cnt(xfer_cnt)
`else
    .bus(bus.slave)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag,
                         input logic v,
                         input logic [7:0] d,
                         input logic [2:0] ch);
    chk({tag, ".valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    chk({tag, ".data"}, {24'd0, bus.out_data}, {24'd0, d});
    chk({tag, ".ch"}, {29'd0, bus.out_ch}, {29'd0, ch});
  endtask

  task automatic chk_rdy(input string tag, input logic [7:0] r);
    #1;
    chk({tag, ".ready"}, {24'd0, bus.in_ready}, {24'd0, r});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.mode = 1'b0;
    bus.sel  = '0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 8'hFF;
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = 8'(8'h10 + i);

    // reset held two cycles
    tick();
    chk_out("rst1", 1'b0, 8'h00, 3'd0);
    chk_rdy("rst1", 8'h00);
    tick();
    chk_out("rst2", 1'b0, 8'h00, 3'd0);
    chk_rdy("rst2", 8'h00);
`ifdef RR_MUX_XFER_CNT_EN
    chk("rst.cnt", {16'd0, xfer_cnt}, 32'd0);
`endif
    rst = 1'b0;
    chk_rdy("rel", 8'h01);

    // round-robin over all channels, wrapping to 0
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_out($sformatf("rr%0d", i), 1'b1,
              8'(8'h10 + (i % 8)), 3'(i % 8));
      chk_rdy($sformatf("rr%0d", i), 8'(1 << ((i + 1) % 8)));
    end

    // park ptr at 6, then sparse requests 0 and 2
    bus.in_valid = 8'h40;
    chk_rdy("park", 8'h40);
    tick();
    chk_out("park", 1'b1, 8'h16, 3'd6);
    bus.in_valid = 8'h05;
    chk_rdy("sp0", 8'h01);
    tick();
    chk_out("sp0", 1'b1, 8'h10, 3'd0);
    chk_rdy("sp1", 8'h04);
    tick();
    chk_out("sp1", 1'b1, 8'h12, 3'd2);
    chk_rdy("sp2", 8'h01);
    tick();
    chk_out("sp2", 1'b1, 8'h10, 3'd0);

    // fixed select
    bus.mode = 1'b1;
    bus.sel  = 3'd5;
    bus.in_valid = 8'hFF;
    bus.in_data[5*W +: W] = 8'hA5;
    chk_rdy("fx5", 8'h20);
    tick();
    chk_out("fx5", 1'b1, 8'hA5, 3'd5);
    bus.sel = 3'd2;
    bus.in_valid = 8'hFB;
    chk_rdy("fx2", 8'h00);
    tick();
    chk_out("fx2", 1'b0, 8'hA5, 3'd5);
    bus.in_data[5*W +: W] = 8'h15;

    // backpressure: ptr still 0 from last rr grant
    bus.mode = 1'b0;
    bus.in_valid = 8'hFF;
    chk_rdy("bp0", 8'h02);
    tick();
    chk_out("bp0", 1'b1, 8'h11, 3'd1);
    bus.out_ready = 1'b0;
    bus.mode = 1'b1;
    bus.sel  = 3'd6;
    chk_rdy("bpst", 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("bp%0d", i + 1), 1'b1, 8'h11, 3'd1);
      chk_rdy($sformatf("bp%0d", i + 1), 8'h00);
    end
    bus.mode = 1'b0;
    bus.out_ready = 1'b1;
    chk_rdy("bprel", 8'h04);
    tick();
    chk_out("bprel", 1'b1, 8'h12, 3'd2);

    // clean reset, then 3 handshakes, stall, reset mid-stall
    rst = 1'b1;
    tick();
    chk_out("rst3", 1'b0, 8'h00, 3'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("hs%0d", i), 1'b1, 8'(8'h10 + i), 3'(i));
    end
`ifdef RR_MUX_XFER_CNT_EN
    chk("hs.cnt", {16'd0, xfer_cnt}, 32'd3);
`endif
    bus.out_ready = 1'b0;
    chk_rdy("st", 8'h00);
    tick();
    chk_out("st", 1'b1, 8'h13, 3'd3);
`ifdef RR_MUX_XFER_CNT_EN
    chk("st.cnt", {16'd0, xfer_cnt}, 32'd3);
`endif
    rst = 1'b1;
    chk_rdy("strst", 8'h00);
    tick();
    chk_out("strst", 1'b0, 8'h00, 3'd0);
`ifdef RR_MUX_XFER_CNT_EN
    chk("strst.cnt", {16'd0, xfer_cnt}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
